// File: rtl/chain_code_pkg.sv
// Shared chain-code definitions: end-of-chain code, direction deltas,
// serial bit timing defaults and receiver state encoding.
package chain_code_pkg;

  localparam int unsigned CLK_PER_BIT_DEF = 11;
  localparam int unsigned SAMPLE_PT_DEF   = 5;
  localparam logic [3:0]  CODE_END        = 4'd8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // 6-bit two's-complement deltas, so adding them wraps modulo 64
  typedef struct packed {
    logic [5:0] dx;
    logic [5:0] dy;
  } delta_t;

  function automatic delta_t dir_delta(input logic [2:0] code);
    delta_t d;
    case (code)
      3'd0:    d = '{6'd0,  6'h3F};
      3'd1:    d = '{6'd1,  6'h3F};
      3'd2:    d = '{6'd1,  6'd0};
      3'd3:    d = '{6'd1,  6'd1};
      3'd4:    d = '{6'd0,  6'd1};
      3'd5:    d = '{6'h3F, 6'd1};
      3'd6:    d = '{6'h3F, 6'd0};
      default: d = '{6'h3F, 6'h3F};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/chain_code_uart_rx.sv
// Serial frame receiver: 2-flop synchroniser, bit timer and frame FSM for
// 6-bit frames (start 0, 4 data bits LSB-first, stop 1).
module chain_code_uart_rx
  import chain_code_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int unsigned SAMPLE_PT   = SAMPLE_PT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       serial_in,
  output logic       frame_valid,
  output logic [3:0] frame_data,
  output logic       frame_err
);

  logic [1:0] sync_q;
  logic       line;
  rx_state_e  state;
  logic [7:0] bit_timer;
  logic [1:0] bit_idx;
  logic [3:0] shift_q;

  // Synchronise the idle-high serial line into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], serial_in};
  end

  // Synchronised line used by the frame FSM
  always_comb begin
    line = sync_q[1];
  end

  // Frame FSM: start-bit validation, mid-bit data sampling, stop-bit check
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RX_IDLE;
      bit_timer   <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (clear) begin
        state     <= RX_IDLE;
        bit_timer <= '0;
        bit_idx   <= '0;
      end else begin
        case (state)
          RX_IDLE: begin
            if (enable && !line) begin
              state     <= RX_START;
              bit_timer <= '0;
              bit_idx   <= '0;
            end
          end
          RX_START: begin
            if (bit_timer == 8'(SAMPLE_PT - 1)) begin
              bit_timer <= '0;
              state     <= line ? RX_IDLE : RX_DATA;
            end else begin
              bit_timer <= bit_timer + 8'd1;
            end
          end
          RX_DATA: begin
            if (bit_timer == 8'(CLK_PER_BIT - 1)) begin
              bit_timer        <= '0;
              shift_q[bit_idx] <= line;
              bit_idx          <= bit_idx + 2'd1;
              if (bit_idx == 2'd3) state <= RX_STOP;
            end else begin
              bit_timer <= bit_timer + 8'd1;
            end
          end
          RX_STOP: begin
            if (bit_timer == 8'(CLK_PER_BIT - 1)) begin
              bit_timer <= '0;
              state     <= RX_IDLE;
              if (line) begin
                frame_valid <= 1'b1;
                frame_data  <= shift_q;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              bit_timer <= bit_timer + 8'd1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/chain_code_decoder.sv
// Chain-code decoder: receives serial direction codes and walks a 6-bit
// (x,y) cursor from the loaded start pixel, tracking steps and status.
module chain_code_decoder
  import chain_code_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int unsigned SAMPLE_PT   = SAMPLE_PT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [5:0]  start_x,
  input  logic [5:0]  start_y,
  input  logic        serial_in,
  output logic        vec_valid,
  output logic [3:0]  vec_code,
  output logic [5:0]  pix_x,
  output logic [5:0]  pix_y,
  output logic [15:0] step_count,
  output logic        done,
  output logic        closed,
  output logic        framing_error,
  output logic        code_error
);

  logic       frame_valid;
  logic       frame_err;
  logic [3:0] frame_data;
  logic       armed;
  logic [5:0] start_x_q;
  logic [5:0] start_y_q;
  delta_t     delta;

  chain_code_uart_rx #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .SAMPLE_PT   (SAMPLE_PT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .clear       (load),
    .enable      (armed),
    .serial_in   (serial_in),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_err   (frame_err)
  );

  // Direction deltas for the received move code
  always_comb begin
    delta = dir_delta(frame_data[2:0]);
  end

  // Cursor, step counter and sticky status; load overrides a completing frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_valid     <= 1'b0;
      vec_code      <= '0;
      pix_x         <= '0;
      pix_y         <= '0;
      step_count    <= '0;
      done          <= 1'b0;
      closed        <= 1'b0;
      framing_error <= 1'b0;
      code_error    <= 1'b0;
      armed         <= 1'b0;
      start_x_q     <= '0;
      start_y_q     <= '0;
    end else if (load) begin
      vec_valid     <= 1'b0;
      pix_x         <= start_x;
      pix_y         <= start_y;
      start_x_q     <= start_x;
      start_y_q     <= start_y;
      step_count    <= '0;
      done          <= 1'b0;
      closed        <= 1'b0;
      framing_error <= 1'b0;
      code_error    <= 1'b0;
      armed         <= 1'b1;
    end else begin
      vec_valid <= 1'b0;
      if (frame_err && armed) framing_error <= 1'b1;
      if (frame_valid && armed) begin
        vec_valid <= 1'b1;
        vec_code  <= frame_data;
        if (!frame_data[3]) begin
          pix_x <= pix_x + delta.dx;
          pix_y <= pix_y + delta.dy;
          if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
        end else if (frame_data == CODE_END) begin
          done   <= 1'b1;
          closed <= (pix_x == start_x_q) && (pix_y == start_y_q);
          armed  <= 1'b0;
        end else begin
          code_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chain_code_decoder.sv
// Scoreboard bench for chain_code_decoder: stimulus pushes expected vectors
// from a behavioural cursor model, a monitor pops them on each vec_valid.
`timescale 1ns/1ps
module tb_chain_code_decoder;

  logic        clk = 1'b0;
  logic        reset, load, serial_in;
  logic [5:0]  start_x, start_y;
  logic        vec_valid;
  logic [3:0]  vec_code;
  logic [5:0]  pix_x, pix_y;
  logic [15:0] step_count;
  logic        done, closed, framing_error, code_error;

  chain_code_decoder #(.CLK_PER_BIT(11), .SAMPLE_PT(5)) dut (
    .clk(clk), .reset(reset), .load(load), .start_x(start_x), .start_y(start_y),
    .serial_in(serial_in), .vec_valid(vec_valid), .vec_code(vec_code),
    .pix_x(pix_x), .pix_y(pix_y), .step_count(step_count), .done(done),
    .closed(closed), .framing_error(framing_error), .code_error(code_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code; int x; int y; int steps; bit dn; bit cl; bit ce;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   vv_count = 0;
  int   last_vv = -1;
  bit   spacing_on = 0;

  // Behavioural model state
  int m_x, m_y, m_sx, m_sy, m_steps;
  bit m_armed, m_done, m_closed, m_ferr, m_cerr;
  int dxt[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dyt[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) tick();
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_sx = 0; m_sy = 0; m_steps = 0;
    m_armed = 0; m_done = 0; m_closed = 0; m_ferr = 0; m_cerr = 0;
  endtask

  task automatic model_frame(input int code, input bit stop_ok);
    exp_t e;
    if (!m_armed) return;
    if (!stop_ok) begin m_ferr = 1; return; end
    if (code < 8) begin
      m_x = (m_x + dxt[code] + 64) % 64;
      m_y = (m_y + dyt[code] + 64) % 64;
      if (m_steps < 65535) m_steps++;
    end else if (code == 8) begin
      m_done = 1;
      m_closed = (m_x == m_sx) && (m_y == m_sy);
      m_armed = 0;
    end else begin
      m_cerr = 1;
    end
    e.code = code; e.x = m_x; e.y = m_y; e.steps = m_steps;
    e.dn = m_done; e.cl = m_closed; e.ce = m_cerr;
    sbq.push_back(e);
  endtask

  task automatic do_load(input int sx, input int sy);
    start_x = 6'(sx); start_y = 6'(sy);
    load = 1'b1;
    m_sx = sx; m_sy = sy; m_x = sx; m_y = sy; m_steps = 0;
    m_done = 0; m_closed = 0; m_ferr = 0; m_cerr = 0; m_armed = 1;
    tick();
    load = 1'b0;
  endtask

  // ncyc < 66 drives only the leading part of a frame
  task automatic send(input int code, input bit stop_ok, input int ncyc);
    logic [5:0] bits;
    logic [3:0] c4;
    c4 = 4'(code);
    bits = {stop_ok, c4, 1'b0};
    if (ncyc >= 66) model_frame(code, stop_ok);
    for (int i = 0; i < ncyc; i++) begin
      serial_in = bits[i / 11];
      tick();
    end
    serial_in = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin tick(); n++; end
    check("drain", sbq.size(), 0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_pix_x"}, pix_x, m_x);
    check({tag, "_pix_y"}, pix_y, m_y);
    check({tag, "_steps"}, step_count, m_steps);
    check({tag, "_done"}, done, m_done);
    check({tag, "_closed"}, closed, m_closed);
    check({tag, "_ferr"}, framing_error, m_ferr);
    check({tag, "_cerr"}, code_error, m_cerr);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {vec_valid, vec_code, pix_x, pix_y, step_count, done, closed,
                framing_error, code_error}, 64'd0);
  endtask

  // Monitor: every vec_valid must match the oldest expected vector
  always @(negedge clk) begin
    cyc++;
    if (vec_valid === 1'b1) begin
      vv_count++;
      if (sbq.size() == 0) begin
        check("unexpected_vec_valid", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("vec_code", vec_code, e.code);
        check("vec_pix_x", pix_x, e.x);
        check("vec_pix_y", pix_y, e.y);
        check("vec_steps", step_count, e.steps);
        check("vec_done", done, e.dn);
        check("vec_closed", closed, e.cl);
        check("vec_cerr", code_error, e.ce);
      end
      if (spacing_on) begin
        if (last_vv >= 0) check("vec_spacing", cyc - last_vv, 66);
        last_vv = cyc;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1_codes[5] = '{2, 4, 6, 0, 8};
    int vv0, code, gap;
    bit ok;

    reset = 1'b0; load = 1'b0; serial_in = 1'b1; start_x = '0; start_y = '0;
    model_reset();
    repeat (3) tick();
    check_zero("reset_outputs");
    reset = 1'b1;
    idle(3);
    send(2, 1, 66);
    idle(10);
    check_zero("unarmed_ignored");

    // Closed square walk, back-to-back frames
    do_load(10, 20);
    idle(5);
    spacing_on = 1; last_vv = -1; vv0 = vv_count;
    foreach (t1_codes[i]) send(t1_codes[i], 1, 66);
    idle(10);
    spacing_on = 0;
    wait_drain();
    check("t1_pulses", vv_count - vv0, 5);
    check("t1_steps_const", step_count, 4);
    check("t1_closed_const", {done, closed}, 2'b11);
    check_status("t1");

    // Wrap-around below zero, open chain
    do_load(0, 0);
    idle(5);
    send(7, 1, 66); send(8, 1, 66);
    idle(10);
    wait_drain();
    check("t2_pix_const", {pix_x, pix_y}, {6'd63, 6'd63});
    check("t2_closed_const", {done, closed}, 2'b10);
    check_status("t2");

    // Bad stop bit then a good frame
    do_load(30, 30);
    idle(5);
    send(5, 0, 66); idle(5);
    send(3, 1, 66); idle(10);
    wait_drain();
    check("t3_ferr_const", framing_error, 1);
    check("t3_pix_const", {pix_x, pix_y}, {6'd31, 6'd31});
    check_status("t3");

    // Short low glitch on idle line
    do_load(20, 20);
    idle(5);
    serial_in = 1'b0; repeat (3) tick();
    idle(80);
    check_status("t4_glitch");
    send(6, 1, 66); idle(10);
    wait_drain();
    check_status("t4");

    // Invalid code
    send(12, 1, 66); idle(10);
    wait_drain();
    check("t5_cerr_const", code_error, 1);
    check_status("t5");

    // Load mid-frame, then reset mid-frame
    do_load(5, 5);
    idle(5);
    send(2, 1, 66); idle(5);
    send(4, 1, 30);
    do_load(40, 41);
    idle(80);
    wait_drain();
    check_status("t6_load");
    send(0, 1, 66); idle(10);
    wait_drain();
    check_status("t6_after");
    send(1, 1, 25);
    reset = 1'b0;
    model_reset();
    #2;
    check_zero("t6_reset_async");
    repeat (3) tick();
    serial_in = 1'b1;
    reset = 1'b1;
    idle(10);
    send(2, 1, 66); idle(10);
    check_zero("t6_unarmed");
    do_load(9, 9);
    idle(5);
    send(1, 1, 66); idle(10);
    wait_drain();
    check_status("t6_reload");

    // Randomised chains with occasional framing errors and bad codes
    for (int it = 0; it < 6; it++) begin
      do_load(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      idle(int'($urandom_range(3, 10)));
      for (int k = 0; k < 15; k++) begin
        if (k == 14 && ($urandom % 2) == 0) code = 8;
        else if (($urandom % 5) == 0) code = int'($urandom % 16);
        else code = int'($urandom % 8);
        ok = (($urandom % 6) != 0);
        send(code, ok, 66);
        gap = ok ? int'($urandom % 4) : 3 + int'($urandom % 4);
        idle(gap);
      end
      idle(10);
      wait_drain();
      check_status("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
